// File: rtl/stream_ctrl_pkg.sv
// Shared types for the sensor stream frame controller: FSM encoding and
// frame-counter width.
package stream_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GAP = 2'd1,
    ARMED    = 2'd2,
    ACTIVE   = 2'd3
  } state_e;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/stream_frame_ctrl_if.sv
// Sensor-style video bus: frame valid, line valid and a flat multi-channel
// pixel word. No back-pressure; the source advances every clock.
interface stream_frame_ctrl_if #(
  parameter int DW = 40
);

  logic          fval;
  logic          lval;
  logic [DW-1:0] data;

  modport master (output fval, lval, data);
  modport slave  (input  fval, lval, data);

endinterface

// File: rtl/fval_edge_det.sv
// Registers frame valid once and reports frame start (rise) and frame end
// (fall) in the same cycle the new fval level is presented.
module fval_edge_det (
  input  logic                clk,
  input  logic                rst_n,
  stream_frame_ctrl_if.slave  bus,
  output logic                rise,
  output logic                fall
);

  logic fval_d_q;
  logic fval_d_d;

  always_comb begin
    fval_d_d = bus.fval;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fval_d_q <= 1'b0;
    end else begin
      fval_d_q <= fval_d_d;
    end
  end

  assign rise = bus.fval & ~fval_d_q;
  assign fall = ~bus.fval & fval_d_q;

endmodule

// File: rtl/stream_frame_ctrl.sv
// Gates a sensor stream so only whole frames pass while streaming is enabled,
// latching per-frame format settings and counting completed output frames.
module stream_frame_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32
) (
  input  logic                                 clk_pix,
  input  logic                                 reset_pix_n,
  input  logic                                 i_fval,
  input  logic                                 i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                                 i_stream_enable,
  input  logic                                 i_acquisition_start,
  input  logic                                 i_encrypt_state,
  input  logic [REG_WD-1:0]                    iv_pixel_format,
  input  logic [2:0]                           iv_test_image,
  output logic                                 o_fval,
  output logic                                 o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic [REG_WD-1:0]                    ov_pixel_format,
  output logic [2:0]                           ov_test_image,
  output logic                                 o_full_frame_state,
  output logic [FRAME_CNT_W-1:0]               ov_frame_cnt
);

  localparam int DW = SENSOR_DAT_WIDTH * CHANNEL_NUM;

  stream_frame_ctrl_if #(.DW(DW)) sensor_bus ();

  assign sensor_bus.fval = i_fval;
  assign sensor_bus.lval = i_lval;
  assign sensor_bus.data = iv_pix_data;

  logic frame_start;
  logic frame_end;

  fval_edge_det u_fval_edge (
    .clk   (clk_pix),
    .rst_n (reset_pix_n),
    .bus   (sensor_bus),
    .rise  (frame_start),
    .fall  (frame_end)
  );

  logic go;
  assign go = i_stream_enable & i_acquisition_start & i_encrypt_state;

  state_e                 state_q, state_d;
  logic [REG_WD-1:0]      pixel_format_q, pixel_format_d;
  logic [2:0]             test_image_q, test_image_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   fval_o_q, fval_o_d;
  logic                   lval_o_q, lval_o_d;
  logic [DW-1:0]          pix_data_q, pix_data_d;
  logic                   full_frame_q, full_frame_d;
  logic                   gate;

  always_comb begin
    state_d        = state_q;
    pixel_format_d = pixel_format_q;
    test_image_d   = test_image_q;
    frame_cnt_d    = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (go) state_d = sensor_bus.fval ? WAIT_GAP : ARMED;
      end
      WAIT_GAP: begin
        if (!go)                  state_d = IDLE;
        else if (!sensor_bus.fval) state_d = ARMED;
      end
      ARMED: begin
        if (frame_start && go) begin
          state_d        = ACTIVE;
          pixel_format_d = iv_pixel_format;
          test_image_d   = iv_test_image;
        end else if (!go) begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        // go is only looked at once the frame has ended, so frames never truncate
        if (frame_end) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = go ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Opening the gate on the transition into ACTIVE aligns the first output
    // cycle with the delayed frame-start cycle.
    gate         = (state_q == ACTIVE) || (state_d == ACTIVE);
    fval_o_d     = gate & sensor_bus.fval;
    lval_o_d     = gate & sensor_bus.fval & sensor_bus.lval;
    pix_data_d   = gate ? sensor_bus.data : '0;
    full_frame_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      state_q        <= IDLE;
      pixel_format_q <= '0;
      test_image_q   <= '0;
      frame_cnt_q    <= '0;
      fval_o_q       <= 1'b0;
      lval_o_q       <= 1'b0;
      pix_data_q     <= '0;
      full_frame_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pixel_format_q <= pixel_format_d;
      test_image_q   <= test_image_d;
      frame_cnt_q    <= frame_cnt_d;
      fval_o_q       <= fval_o_d;
      lval_o_q       <= lval_o_d;
      pix_data_q     <= pix_data_d;
      full_frame_q   <= full_frame_d;
    end
  end

  assign o_fval             = fval_o_q;
  assign o_lval             = lval_o_q;
  assign ov_pix_data        = pix_data_q;
  assign ov_pixel_format    = pixel_format_q;
  assign ov_test_image      = test_image_q;
  assign o_full_frame_state = full_frame_q;
  assign ov_frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_stream_frame_ctrl.sv
// Directed bench for stream_frame_ctrl: whole-frame gating, parameter latching,
// reset behaviour and frame counting, each scenario in its own task.
module tb_stream_frame_ctrl;

  localparam int SW = 10;
  localparam int CN = 4;
  localparam int RW = 32;
  localparam int DW = SW * CN;

  logic          clk_pix;
  logic          reset_pix_n;
  logic          i_stream_enable;
  logic          i_acquisition_start;
  logic          i_encrypt_state;
  logic [RW-1:0] iv_pixel_format;
  logic [2:0]    iv_test_image;
  logic [RW-1:0] ov_pixel_format;
  logic [2:0]    ov_test_image;
  logic          o_full_frame_state;
  logic [15:0]   ov_frame_cnt;

  int n_chk;
  int n_err;
  int total_pulses;

  stream_frame_ctrl_if #(.DW(DW)) sensor_if ();
  stream_frame_ctrl_if #(.DW(DW)) out_if ();

  stream_frame_ctrl #(
    .SENSOR_DAT_WIDTH (SW),
    .CHANNEL_NUM      (CN),
    .REG_WD           (RW)
  ) dut (
    .clk_pix             (clk_pix),
    .reset_pix_n         (reset_pix_n),
    .i_fval              (sensor_if.fval),
    .i_lval              (sensor_if.lval),
    .iv_pix_data         (sensor_if.data),
    .i_stream_enable     (i_stream_enable),
    .i_acquisition_start (i_acquisition_start),
    .i_encrypt_state     (i_encrypt_state),
    .iv_pixel_format     (iv_pixel_format),
    .iv_test_image       (iv_test_image),
    .o_fval              (out_if.fval),
    .o_lval              (out_if.lval),
    .ov_pix_data         (out_if.data),
    .ov_pixel_format     (ov_pixel_format),
    .ov_test_image       (ov_test_image),
    .o_full_frame_state  (o_full_frame_state),
    .ov_frame_cnt        (ov_frame_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Inputs change at a falling edge; on return the outputs reflect them.
  task automatic drive(input logic f, input logic l, input logic [DW-1:0] d);
    sensor_if.fval = f;
    sensor_if.lval = l;
    sensor_if.data = d;
    @(negedge clk_pix);
  endtask

  task automatic send_frame(input string name, input int lines, input int lw,
                            input int gap, input bit exp_out, input int ev_cyc,
                            input logic ev_se, input logic [RW-1:0] ev_fmt,
                            input bit lval_gap);
    int flen;
    int pulses;
    int bad;
    logic prev_f;
    logic f, l, ef, el;
    logic [DW-1:0] d, ed;
    flen   = lines * lw + lines - 1;
    pulses = 0;
    bad    = 0;
    prev_f = out_if.fval;
    for (int c = 0; c < flen + gap; c++) begin
      if (c == ev_cyc) begin
        i_stream_enable = ev_se;
        iv_pixel_format = ev_fmt;
      end
      f = (c < flen);
      l = f ? ((c % (lw + 1)) < lw) : lval_gap;
      d = rand_data();
      drive(f, l, d);
      ef = exp_out & f;
      el = exp_out & f & l;
      ed = (exp_out && c <= flen) ? d : '0;
      if (out_if.fval && !prev_f) pulses++;
      prev_f = out_if.fval;
      if ({out_if.fval, out_if.lval, o_full_frame_state, out_if.data} !== {ef, el, ef, ed}) begin
        if (bad == 0)
          $display("FAIL %s_cycle%0d: got fval=%b lval=%b ffs=%b data=%h, want fval=%b lval=%b ffs=%b data=%h",
                   name, c, out_if.fval, out_if.lval, o_full_frame_state, out_if.data, ef, el, ef, ed);
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) n_err++;
    n_chk++;
    if (pulses != (exp_out ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s_pulses: got %0d want %0d", name, pulses, exp_out ? 1 : 0);
    end
    total_pulses += pulses;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_pix_n         = 1'b0;
    i_stream_enable     = 1'b0;
    i_acquisition_start = 1'b0;
    i_encrypt_state     = 1'b0;
    iv_pixel_format     = 32'h0108_0001;
    iv_test_image       = 3'd3;
    sensor_if.fval      = 1'b0;
    sensor_if.lval      = 1'b0;
    sensor_if.data      = '0;
    repeat (3) @(negedge clk_pix);
    n_chk++;
    if ({out_if.fval, out_if.lval, o_full_frame_state, out_if.data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got fval=%b lval=%b ffs=%b data=%h want all 0",
               out_if.fval, out_if.lval, o_full_frame_state, out_if.data);
    end
    n_chk++;
    if (ov_frame_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_frame_cnt: got %h want 0000", ov_frame_cnt);
    end
    n_chk++;
    if (ov_pixel_format !== 32'h0 || ov_test_image !== 3'd0) begin
      n_err++;
      $display("FAIL reset_params: got fmt=%h ti=%0d want 0/0", ov_pixel_format, ov_test_image);
    end
    reset_pix_n = 1'b1;
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    n_chk++;
    if (out_if.fval !== 1'b0 || o_full_frame_state !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got fval=%b ffs=%b want 0/0", out_if.fval, o_full_frame_state);
    end
  endtask

  task automatic test_steady_run();
    i_stream_enable     = 1'b1;
    i_acquisition_start = 1'b1;
    i_encrypt_state     = 1'b1;
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    total_pulses = 0;
    for (int i = 0; i < 30; i++)
      send_frame($sformatf("steady%0d", i), 1, 1, 1, 1'b1, -1, 1'b1, iv_pixel_format, 1'b0);
    n_chk++;
    if (total_pulses != 30) begin
      n_err++;
      $display("FAIL steady_pulses: got %0d want 30", total_pulses);
    end
    n_chk++;
    if (ov_frame_cnt !== 16'd30) begin
      n_err++;
      $display("FAIL steady_frame_cnt: got %0d want 30", ov_frame_cnt);
    end
    n_chk++;
    if (ov_pixel_format !== 32'h0108_0001 || ov_test_image !== 3'd3) begin
      n_err++;
      $display("FAIL steady_params: got fmt=%h ti=%0d want 01080001/3", ov_pixel_format, ov_test_image);
    end
  endtask

  task automatic test_mid_frame_start();
    i_stream_enable = 1'b0;
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    send_frame("start_n", 8, 4, 2, 1'b0, 20, 1'b1, iv_pixel_format, 1'b0);
    send_frame("start_n1", 8, 4, 2, 1'b1, -1, 1'b1, iv_pixel_format, 1'b0);
    n_chk++;
    if (ov_frame_cnt !== 16'd31) begin
      n_err++;
      $display("FAIL start_frame_cnt: got %0d want 31", ov_frame_cnt);
    end
  endtask

  task automatic test_mid_frame_stop();
    send_frame("stop_n", 8, 4, 2, 1'b1, 20, 1'b0, iv_pixel_format, 1'b0);
    send_frame("stop_n1", 8, 4, 2, 1'b0, -1, 1'b0, iv_pixel_format, 1'b0);
    n_chk++;
    if (ov_frame_cnt !== 16'd32) begin
      n_err++;
      $display("FAIL stop_frame_cnt: got %0d want 32", ov_frame_cnt);
    end
  endtask

  task automatic test_go_with_frame_start();
    send_frame("coinc_n", 2, 3, 2, 1'b0, 0, 1'b1, iv_pixel_format, 1'b0);
    send_frame("coinc_n1", 2, 3, 2, 1'b1, -1, 1'b1, iv_pixel_format, 1'b0);
    n_chk++;
    if (ov_frame_cnt !== 16'd33) begin
      n_err++;
      $display("FAIL coinc_frame_cnt: got %0d want 33", ov_frame_cnt);
    end
  endtask

  task automatic test_go_toggle_armed();
    int bad;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      i_acquisition_start = i[0];
      drive(1'b0, 1'b0, rand_data());
      if ({out_if.fval, out_if.lval, o_full_frame_state, out_if.data} !== '0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL toggle_quiet: got %0d active cycles want 0", bad);
    end
    send_frame("toggle_after", 2, 3, 2, 1'b1, -1, 1'b1, iv_pixel_format, 1'b0);
    n_chk++;
    if (ov_frame_cnt !== 16'd34) begin
      n_err++;
      $display("FAIL toggle_frame_cnt: got %0d want 34", ov_frame_cnt);
    end
  endtask

  task automatic test_param_hold();
    iv_test_image = 3'd5;
    send_frame("hold_n", 8, 4, 2, 1'b1, 20, 1'b1, 32'h010C_0005, 1'b0);
    n_chk++;
    if (ov_pixel_format !== 32'h0108_0001 || ov_test_image !== 3'd5) begin
      n_err++;
      $display("FAIL hold_old: got fmt=%h ti=%0d want 01080001/5", ov_pixel_format, ov_test_image);
    end
    iv_test_image = 3'd6;
    send_frame("hold_n1", 2, 2, 2, 1'b1, -1, 1'b1, iv_pixel_format, 1'b0);
    n_chk++;
    if (ov_pixel_format !== 32'h010C_0005 || ov_test_image !== 3'd6) begin
      n_err++;
      $display("FAIL hold_new: got fmt=%h ti=%0d want 010C0005/6", ov_pixel_format, ov_test_image);
    end
  endtask

  task automatic test_lval_outside_fval();
    send_frame("lval_gap", 3, 4, 3, 1'b1, -1, 1'b1, iv_pixel_format, 1'b1);
    n_chk++;
    if (ov_frame_cnt !== 16'd37) begin
      n_err++;
      $display("FAIL lval_frame_cnt: got %0d want 37", ov_frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int flen;
    int seen;
    logic f, l;
    flen = 6 * 4 + 5;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      f = 1'b1;
      l = (c % 5) < 4;
      drive(f, l, rand_data());
    end
    n_chk++;
    if (out_if.fval !== 1'b1 || out_if.lval !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_active: got fval=%b lval=%b want 1/1", out_if.fval, out_if.lval);
    end
    reset_pix_n = 1'b0;
    #1;
    n_chk++;
    if ({out_if.fval, out_if.lval, o_full_frame_state, out_if.data} !== '0) begin
      n_err++;
      $display("FAIL rst_immediate: got fval=%b lval=%b ffs=%b data=%h want all 0",
               out_if.fval, out_if.lval, o_full_frame_state, out_if.data);
    end
    n_chk++;
    if (ov_frame_cnt !== 16'h0 || ov_pixel_format !== 32'h0 || ov_test_image !== 3'd0) begin
      n_err++;
      $display("FAIL rst_regs: got cnt=%h fmt=%h ti=%0d want 0/0/0", ov_frame_cnt, ov_pixel_format, ov_test_image);
    end
    for (int c = 12; c < flen + 2; c++) begin
      if (c == 15) reset_pix_n = 1'b1;
      f = (c < flen);
      l = f && ((c % 5) < 4);
      drive(f, l, rand_data());
      if (out_if.fval || out_if.lval || o_full_frame_state) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_partial_frame: got %0d output cycles want 0", seen);
    end
    send_frame("rst_next", 2, 3, 2, 1'b1, -1, 1'b1, iv_pixel_format, 1'b0);
    n_chk++;
    if (ov_frame_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL rst_frame_cnt: got %0d want 1", ov_frame_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    force dut.frame_cnt_q = 16'hFFFF;
    drive(1'b0, 1'b0, '0);
    release dut.frame_cnt_q;
    drive(1'b0, 1'b0, '0);
    n_chk++;
    if (ov_frame_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_preload: got %h want ffff", ov_frame_cnt);
    end
    send_frame("wrap", 1, 2, 2, 1'b1, -1, 1'b1, iv_pixel_format, 1'b0);
    n_chk++;
    if (ov_frame_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap_frame_cnt: got %h want 0000", ov_frame_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_chk        = 0;
    n_err        = 0;
    total_pulses = 0;
    test_reset();
    test_steady_run();
    test_mid_frame_start();
    test_mid_frame_stop();
    test_go_with_frame_start();
    test_go_toggle_armed();
    test_param_hold();
    test_lval_outside_fval();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
